wallace_mac: RTL and testbench

WALLACE_MAC -- requirements
Module: wallace_mac

---
 rtl/wallace_mac_pkg.sv | 13 +
 rtl/wallace_mac_eightwallace.sv | 40 ++++
 rtl/wallace_mac.sv | 96 +++++++++
 tb/tb_wallace_mac.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wallace_mac_pkg.sv
// Shared widths and result-FSM encoding for the Wallace-tree multiply-accumulate block.
package wallace_mac_pkg;

  localparam int unsigned OP_W  = 8;
  localparam int unsigned ACC_W = 24;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } res_state_t;

endpackage

// File: rtl/wallace_mac_eightwallace.sv
// Combinational 8x8 unsigned multiplier: partial products reduced by a tree of
// carry-save adders, then a single carry-propagate add.
module eightwallace
  import wallace_mac_pkg::*;
(
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic [2*OP_W-1:0] prod
);

  localparam int unsigned PW = 2 * OP_W;

  // Returns {carry<<1, sum} for three equally weighted rows.
  function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] x, y, z);
    logic [PW-1:0] maj;
    maj = (x & y) | (x & z) | (y & z);
    return {maj[PW-2:0], 1'b0, x ^ y ^ z};
  endfunction

  logic [PW-1:0] pp [OP_W];

  always_comb begin
    for (int unsigned i = 0; i < OP_W; i++) begin
      pp[i] = {{OP_W{1'b0}}, A & {OP_W{B[i]}}} << i;
    end
  end

  logic [PW-1:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  // 8 rows -> 6 -> 4 -> 3 -> 2
  assign {c0, s0} = csa(pp[0], pp[1], pp[2]);
  assign {c1, s1} = csa(pp[3], pp[4], pp[5]);
  assign {c2, s2} = csa(s0, c0, s1);
  assign {c3, s3} = csa(c1, pp[6], pp[7]);
  assign {c4, s4} = csa(s2, c2, s3);
  assign {c5, s5} = csa(s4, c4, c3);

  assign prod = s5 + c5;

endmodule

// File: rtl/wallace_mac.sv
// Streaming dot-product MAC: registered product stage, accumulate stage and a
// held result register with valid/ready handshakes on both sides.
module wallace_mac
  import wallace_mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  logic [2*OP_W-1:0] prod;
  logic [2*OP_W-1:0] p_prod;
  logic              p_valid;
  logic              p_last;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  res_state_t        state;

  logic              stall;
  logic              accept;
  logic              load;
  logic [ACC_W:0]    acc_next;
  logic [CNT_W-1:0]  cnt_next;
  logic              ovf_next;

  eightwallace u_mul (
    .A    (a),
    .B    (b),
    .prod (prod)
  );

  // A last element may only leave stage P once the result register can take it.
  assign stall    = p_valid && p_last && out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  assign load     = p_valid && p_last && !stall;

  assign acc_next  = {1'b0, acc} + {{(ACC_W + 1 - 2 * OP_W){1'b0}}, p_prod};
  assign cnt_next  = cnt + {{(CNT_W - 1){1'b0}}, 1'b1};
  assign ovf_next  = ovf | acc_next[ACC_W];
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_valid   <= 1'b0;
      p_last    <= 1'b0;
      p_prod    <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      state     <= IDLE;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (!stall) begin
        p_valid <= accept;
        if (accept) begin
          p_prod <= prod;
          p_last <= in_last;
        end
        if (p_valid) begin
          if (p_last) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= acc_next[ACC_W-1:0];
            out_count <= cnt_next;
            out_ovf   <= ovf_next;
          end else begin
            acc <= acc_next[ACC_W-1:0];
            cnt <= cnt_next;
            ovf <= ovf_next;
          end
        end
      end

      case (state)
        IDLE:    if (load) state <= HOLD;
        HOLD:    if (!load && out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wallace_mac.sv
// Directed-vector and random-stall bench for wallace_mac.
module tb_wallace_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sum;
  logic [15:0] out_count;
  logic        out_ovf;

  int checks   = 0;
  int failures = 0;

  wallace_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        last;
    logic [23:0] sum;
    logic [15:0] cnt;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [23:0] sum;
    logic [15:0] cnt;
    logic        ovf;
  } res_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] xa, input logic [7:0] xb, input logic l);
    in_valid = v;
    a        = xa;
    b        = xb;
    in_last  = l;
  endtask

  task automatic chk_res(input string nm, input logic [23:0] s, input logic [15:0] c, input logic o);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_sum"}, out_sum, s);
    chk({nm, "_count"}, out_count, c);
    chk({nm, "_ovf"}, out_ovf, o);
  endtask

  vec_t tbl [11];

  initial begin
    res_t        exp_q [$];
    res_t        r;
    longint      m_sum;
    int          m_cnt;
    int          sent;
    int          rem;
    int          cycles;
    logic        pending;
    logic        acc_fire, out_fire;

    tbl[0]  = '{8'd255, 8'd255, 1'b1, 24'd65025, 16'd1, 1'b0};
    tbl[1]  = '{8'd3,   8'd4,   1'b0, 24'd0,     16'd0, 1'b0};
    tbl[2]  = '{8'd5,   8'd6,   1'b0, 24'd0,     16'd0, 1'b0};
    tbl[3]  = '{8'd7,   8'd8,   1'b1, 24'd98,    16'd3, 1'b0};
    tbl[4]  = '{8'd2,   8'd2,   1'b1, 24'd4,     16'd1, 1'b0};
    tbl[5]  = '{8'd255, 8'd1,   1'b0, 24'd0,     16'd0, 1'b0};
    tbl[6]  = '{8'd1,   8'd255, 1'b1, 24'd510,   16'd2, 1'b0};
    tbl[7]  = '{8'd16,  8'd16,  1'b1, 24'd256,   16'd1, 1'b0};
    tbl[8]  = '{8'd0,   8'd200, 1'b1, 24'd0,     16'd1, 1'b0};
    tbl[9]  = '{8'd128, 8'd2,   1'b0, 24'd0,     16'd0, 1'b0};
    tbl[10] = '{8'd15,  8'd17,  1'b1, 24'd511,   16'd2, 1'b0};

    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Table: one element per cycle, results checked one edge after their last accept.
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].last);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), in_ready, 1);
      tick();
      if (i > 0) begin
        if (tbl[i-1].last)
          chk_res($sformatf("tbl%0d", i - 1), tbl[i-1].sum, tbl[i-1].cnt, tbl[i-1].ovf);
        else
          chk($sformatf("tbl%0d_noresult", i - 1), out_valid, 0);
      end
    end
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    tick();
    chk_res("tbl10", tbl[10].sum, tbl[10].cnt, tbl[10].ovf);
    tick();
    chk("tbl_drain_valid", out_valid, 0);

    // Long vectors around the 2^24 boundary.
    for (int n = 258; n <= 259; n++) begin
      for (int i = 1; i <= n; i++) begin
        drive(1'b1, 8'd255, 8'd255, i == n);
        tick();
      end
      drive(1'b0, 8'd0, 8'd0, 1'b0);
      tick();
      if (n == 258) chk_res("len258", 24'd16776450, 16'd258, 1'b0);
      else          chk_res("len259", 24'd64259, 16'd259, 1'b1);
      tick();
    end

    // Backpressure: second vector's last element waits behind a held result.
    out_ready = 1'b0;
    drive(1'b1, 8'd3, 8'd4, 1'b0); tick();
    drive(1'b1, 8'd5, 8'd6, 1'b0); tick();
    drive(1'b1, 8'd7, 8'd8, 1'b1); tick();
    drive(1'b1, 8'd1, 8'd1, 1'b1); tick();
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    chk_res("bp_hold", 24'd98, 16'd3, 1'b0);
    chk("bp_in_ready_low", in_ready, 0);
    tick();
    tick();
    chk_res("bp_stable", 24'd98, 16'd3, 1'b0);
    chk("bp_in_ready_still_low", in_ready, 0);
    out_ready = 1'b1;
    tick();
    chk_res("bp_next", 24'd1, 16'd1, 1'b0);
    chk("bp_in_ready_back", in_ready, 1);
    tick();
    chk("bp_release_valid", out_valid, 0);

    // Reset in the middle of a vector.
    drive(1'b1, 8'd1, 8'd2, 1'b0); tick();
    drive(1'b1, 8'd3, 8'd4, 1'b0); tick();
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", out_sum, 0);
    chk("mid_rst_count", out_count, 0);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    tick();
    tick();
    chk("mid_rst_no_output", out_valid, 0);
    drive(1'b1, 8'd9, 8'd9, 1'b1); tick();
    drive(1'b0, 8'd0, 8'd0, 1'b0); tick();
    chk_res("after_rst", 24'd81, 16'd1, 1'b0);
    tick();

    // Reset while a result is held.
    out_ready = 1'b0;
    drive(1'b1, 8'd5, 8'd5, 1'b1); tick();
    drive(1'b0, 8'd0, 8'd0, 1'b0); tick();
    chk_res("hold_pre_rst", 24'd25, 16'd1, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("hold_rst_valid", out_valid, 0);
    chk("hold_rst_sum", out_sum, 0);
    tick();
    tick();
    chk("hold_rst_no_output", out_valid, 0);

    // Random-stall soak against a reference sum.
    m_sum = 0; m_cnt = 0; sent = 0; rem = 0; cycles = 0; pending = 1'b0;
    while (cycles < 60000 && (sent < 10000 || exp_q.size() > 0)) begin
      if (!pending && sent < 10000) begin
        if (rem == 0) rem = $urandom_range(1, 8);
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        in_last = (rem == 1) || (sent == 9999);
        pending = 1'b1;
      end
      in_valid  = pending && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc_fire = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          chk("soak_unexpected_result", 1, 0);
        end else begin
          r = exp_q.pop_front();
          chk("soak_sum", out_sum, r.sum);
          chk("soak_count", out_count, r.cnt);
          chk("soak_ovf", out_ovf, r.ovf);
        end
      end
      if (acc_fire) begin
        m_sum += longint'(a) * longint'(b);
        m_cnt++;
        sent++;
        rem--;
        pending = 1'b0;
        if (in_last) begin
          r.sum = 24'(m_sum);
          r.cnt = 16'(m_cnt);
          r.ovf = (m_sum >> 24) != 0;
          exp_q.push_back(r);
          m_sum = 0;
          m_cnt = 0;
          rem = 0;
        end
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    in_valid = 1'b0;
    chk("soak_elements", sent, 10000);
    chk("soak_pending_results", exp_q.size(), 0);
    chk("soak_timeout", cycles < 60000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
